chdr_pkt_arbiter: RTL and testbench
===================================

// Module: chdr_pkt_arbiter
// PURPOSE
//  Packet-atomic arbiter sharing one 64-bit CHDR output stream among NUM_INPUTS framed CHDR sources
//  (e.g. several chdr_framer outputs feeding one crossbar port). Grants a whole packet (header..tlast),
//  round-robin or fixed-priority, checks each packet's beat count against its CHDR length field,
//  and reports errors and packet counts.
// PARAMETERS
//  NUM_INPUTS  4   number of requesting CHDR streams, 2..16
//  PRIO        0   0 = round-robin; 1 = fixed priority, lowest index wins
//  IDX_W       $clog2(NUM_INPUTS)  derived, width of grant index (localparam, not overridable)
// PORTS
//  clk          in   1              clock
//  reset        in   1              synchronous, active-high reset
//  clear        in   1              synchronous soft clear, same effect as reset
//  i_tdata      in   64*NUM_INPUTS  input words, port k at [64k+63:64k]
//  i_tlast      in   NUM_INPUTS     per-port end of packet
//  i_tvalid     in   NUM_INPUTS     per-port valid
//  i_tready     out  NUM_INPUTS     per-port ready
//  o_tdata      out  64             arbitrated output word
//  o_tlast      out  1              output end of packet
//  o_tvalid     out  1              output valid
//  o_tready     in   1              output ready
//  o_grant_idx  out  IDX_W          index of currently/last granted port
//  o_busy       out  1              high while a packet is granted (ST_HEAD/ST_BODY)
//  o_len_err    out  1              one-cycle pulse: completed packet beat count != header length
//  o_pkt_count  out  32             packets forwarded since reset/clear, wraps at 2^32
// BEHAVIOUR
//  Reset/clear: state=ST_IDLE, i_tready=0, o_tvalid=0, o_tlast=0, o_grant_idx=0, o_busy=0,
//    o_len_err=0, o_pkt_count=0, rr pointer=0. Clear mid-packet abandons the grant; the downstream
//    sees a truncated packet. This is accepted and is the caller's responsibility.
//  States:
//    ST_IDLE: if any i_tvalid, then register grant = pick(i_tvalid, ptr) -> ST_HEAD.
//      No data is moved in ST_IDLE. Bubble: 1 cycle per packet.
//    ST_HEAD: the granted port is passed through. On beat (o_tvalid&o_tready):
//      - capture len = o_tdata[47:32];
//      - exp_beats = (len+7)>>3, 17-bit arithmetic, no overflow;
//      - beat counter = 1.
//      If tlast also set -> finish packet, else -> ST_BODY.
//    ST_BODY: pass-through. Each beat increments the beat counter (16 bits, saturating).
//      On beat with tlast -> finish packet.
//    Finish packet:
//      - o_len_err pulses next cycle if final count != exp_beats, or if len < 8;
//      - o_pkt_count+1;
//      - RR ptr = grant+1 mod NUM_INPUTS;
//      - -> ST_IDLE.
//  Pass-through is combinational: o_tdata/o_tlast/o_tvalid = granted port's signals in ST_HEAD/BODY,
//    else o_tvalid=0. i_tready[g] = o_tready only for granted g in ST_HEAD/BODY; all others 0.
//  pick(): RR = first asserted valid at or after ptr, cyclically; PRIO=1 = lowest asserted index.
//    The ptr is ignored when PRIO=1.
//  Packets are never interleaved. A count mismatch does not cut the packet short: the grant holds
//    until tlast. A valid that drops mid-packet stalls the output and keeps the grant.
//  No input is dropped. An input stays unready until granted. Throughput: L beats per L+1 cycles.
//  o_grant_idx updates at the ST_IDLE decision and holds until the next decision.
//  o_busy = (state != ST_IDLE).
// STRUCTURE
//  Shared package chdr_pkg: CHDR header field offsets (LEN_MSB=47, LEN_LSB=32, HAS_TIME bit 61,
//    EOB bit 60) and state encodings ST_IDLE/ST_HEAD/ST_BODY.
//  Sub-module chdr_rr_pick (params N, PRIO): combinational rotating-mask priority encoder.
//    Inputs: req[N], ptr.
//    Outputs: gnt_idx, gnt_vld.
//  Top level holds the FSM, the beat/length check, counters and the pass-through muxes.
// TESTING
//  1. Only port 2 valid, 3-beat pkt with len=24, o_tready=1.
//     -> grant_idx=2; 1 idle cycle, then 3 beats out; o_tlast on beat 3; len_err=0; pkt_count=1.
//  2. All 4 ports continuously valid, 1-beat pkts (len=8), RR.
//     -> grant order 0,1,2,3,0,1,... Output beats every 2nd cycle.
//  3. Same as 2 with PRIO=1. -> port 0 granted every packet; ports 1-3 i_tready stay 0.
//  4. Port 1 sends a 4-beat pkt with header len=16.
//     -> all 4 beats forwarded intact; o_len_err pulses 1 cycle after tlast; pkt_count increments.
//  5. o_tready toggled randomly while ports 0 and 3 both send 5-beat pkts.
//     -> no interleaving; words are bit-exact per packet; order is 0,3,0,3.
//  6. Assert clear mid-ST_BODY.
//     -> next cycle: state IDLE, o_tvalid=0, pkt_count=0, ptr=0; the next grant goes to the lowest valid port.

Source files
------------

// File: rtl/chdr_pkg.sv
// CHDR header field positions, arbiter state encodings and length helpers.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package chdr_pkg;

  // CHDR header word field positions
  localparam int LEN_MSB      = 47;
  localparam int LEN_LSB      = 32;
  localparam int HAS_TIME_BIT = 61;
  localparam int EOB_BIT      = 60;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  // Number of 64-bit beats implied by a byte length. Done in 17 bits so a
  // length near 0xFFFF cannot wrap when rounding up.
  function automatic logic [16:0] len_to_beats(input logic [15:0] len);
    return ({1'b0, len} + 17'd7) >> 3;
  endfunction

endpackage

// File: rtl/chdr_rr_pick.sv
// Rotating-mask priority encoder choosing one requester.
// Latency: combinational.
// Backpressure: none; purely a function of req and ptr.
//
// Ports:
//   req      requests, one bit per input
//   ptr      round-robin start index (ignored when PRIO=1)
//   gnt_idx  chosen index (0 when nothing requests)
//   gnt_vld  any request present
module chdr_rr_pick #(
  parameter  int N    = 4,
  parameter  int PRIO = 0,
  localparam int IW   = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic found;

  always_comb begin
    gnt_vld = |req;
    gnt_idx = '0;
    found   = 1'b0;
    // Round-robin: lowest request at or above ptr. Scanning downward and
    // overwriting leaves the lowest matching index in gnt_idx.
    if (PRIO == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i] && (i >= int'(ptr))) begin
          gnt_idx = IW'(i);
          found   = 1'b1;
        end
      end
    end
    // Nothing at/above ptr (or fixed priority): wrap to the lowest request.
    if (!found) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/chdr_pkt_arbiter.sv
// Packet-atomic arbiter merging NUM_INPUTS CHDR streams onto one 64-bit output.
// Latency: data path is combinational pass-through; one idle cycle per packet for the grant decision.
// Backpressure: o_tready goes straight to the granted input's i_tready; all other inputs held unready.
//
// Ports:
//   clk, reset, clear          clock, sync active-high reset, sync soft clear (same effect)
//   i_tdata/i_tlast/i_tvalid   per-input streams, port k data at [64k+63:64k]
//   i_tready                   per-input ready
//   o_tdata/o_tlast/o_tvalid   merged output stream, o_tready from downstream
//   o_grant_idx, o_busy        current/last grant, packet in progress
//   o_len_err                  1-cycle pulse after a packet whose beat count disagrees with its length
//   o_pkt_count                packets forwarded, wrapping
module chdr_pkt_arbiter
  import chdr_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int PRIO       = 0,
  localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [64*NUM_INPUTS-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]    i_tlast,
  input  logic [NUM_INPUTS-1:0]    i_tvalid,
  output logic [NUM_INPUTS-1:0]    i_tready,
  output logic [63:0]              o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output logic [IDX_W-1:0]         o_grant_idx,
  output logic                     o_busy,
  output logic                     o_len_err,
  output logic [31:0]              o_pkt_count
);

  logic [1:0]       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      len_q;
  logic [15:0]      beats_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             busy;
  logic             beat;
  logic [15:0]      cur_len;
  logic [15:0]      cur_beats;
  logic             pkt_bad;

  chdr_rr_pick #(
    .N    (NUM_INPUTS),
    .PRIO (PRIO)
  ) u_pick (
    .req     (i_tvalid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    o_tdata  = i_tdata[64*int'(grant) +: 64];
    o_tlast  = busy & i_tlast[grant];
    o_tvalid = busy & i_tvalid[grant];
    i_tready = '0;
    if (busy) i_tready[grant] = o_tready;
  end

  assign beat = o_tvalid & o_tready;

  // On the header beat the length comes straight off the bus and the count
  // starts at 1; afterwards use the captured length and a saturating count.
  assign cur_len   = (state == ST_HEAD) ? o_tdata[LEN_MSB:LEN_LSB] : len_q;
  assign cur_beats = (state == ST_HEAD) ? 16'd1 :
                     (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
  assign pkt_bad   = ({1'b0, cur_beats} != len_to_beats(cur_len)) || (cur_len < 16'd8);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= ST_IDLE;
      grant       <= '0;
      ptr         <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      o_len_err   <= 1'b0;
      o_pkt_count <= '0;
    end else begin
      o_len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            state <= ST_HEAD;
          end
        end
        ST_HEAD, ST_BODY: begin
          if (beat) begin
            len_q   <= cur_len;
            beats_q <= cur_beats;
            if (o_tlast) begin
              o_len_err   <= pkt_bad;
              o_pkt_count <= o_pkt_count + 32'd1;
              ptr         <= (grant == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
              state       <= ST_IDLE;
            end else begin
              state <= ST_BODY;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant_idx = grant;
  assign o_busy      = busy;

endmodule

// File: tb/tb_chdr_pkt_arbiter.sv
// Bench for chdr_pkt_arbiter: randomized packet sources checked cycle by cycle
// against a packet-level reference model; one DUT per arbitration policy.
// Latency/backpressure: n/a (testbench).
module tb_chdr_pkt_arbiter;

  localparam int NP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clear;
  logic [64*NP-1:0]  i_tdata;
  logic [NP-1:0]     i_tlast, i_tvalid;
  logic              o_tready;

  logic [NP-1:0] rdy0, rdy1;
  logic [63:0]   d0, d1;
  logic          l0, l1, v0, v1, b0, b1, e0, e1;
  logic [1:0]    g0, g1;
  logic [31:0]   c0, c1;

  chdr_pkt_arbiter #(.NUM_INPUTS(NP), .PRIO(0)) dut_rr (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(rdy0),
    .o_tdata(d0), .o_tlast(l0), .o_tvalid(v0), .o_tready(o_tready),
    .o_grant_idx(g0), .o_busy(b0), .o_len_err(e0), .o_pkt_count(c0)
  );

  chdr_pkt_arbiter #(.NUM_INPUTS(NP), .PRIO(1)) dut_pr (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(rdy1),
    .o_tdata(d1), .o_tlast(l1), .o_tvalid(v1), .o_tready(o_tready),
    .o_grant_idx(g1), .o_busy(b1), .o_len_err(e1), .o_pkt_count(c1)
  );

  // Outputs of whichever DUT is under test
  bit            use_prio = 0;
  logic [NP-1:0] s_rdy;
  logic [63:0]   s_d;
  logic          s_l, s_v, s_b, s_e;
  logic [1:0]    s_g;
  logic [31:0]   s_c;

  always_comb begin
    s_rdy = use_prio ? rdy1 : rdy0;
    s_d   = use_prio ? d1 : d0;
    s_l   = use_prio ? l1 : l0;
    s_v   = use_prio ? v1 : v0;
    s_b   = use_prio ? b1 : b0;
    s_e   = use_prio ? e1 : e0;
    s_g   = use_prio ? g1 : g0;
    s_c   = use_prio ? c1 : c0;
  end

  int total = 0;
  int bad   = 0;

  // Per-port packet sources: bit 64 is tlast
  logic [64:0] pq [NP][$];
  int vld_stall_pct = 0;
  int rdy_stall_pct = 0;

  // Reference model (packet level)
  bit          m_synced = 0;
  bit          m_busy, m_head, m_err;
  int          m_g, m_ptr, m_beats;
  logic [31:0] m_pkts;
  logic [15:0] m_len;

  // Observations
  int cyc = 0;
  int obs_order[$];
  int beat_cycle[$];
  int obs_err, obs_beats;
  logic [NP-1:0] pop_mask;

  function automatic int model_pick(input logic [NP-1:0] v);
    if (use_prio) begin
      for (int k = 0; k < NP; k++) if (v[k]) return k;
    end else begin
      for (int j = 0; j < NP; j++) if (v[(m_ptr + j) % NP]) return (m_ptr + j) % NP;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int port, input int nb, input int len);
    logic [64:0] w;
    for (int b = 0; b < nb; b++) begin
      w = {1'b0, $urandom, $urandom};
      if (b == 0) w[47:32] = len[15:0];
      w[64] = (b == nb - 1);
      pq[port].push_back(w);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NP; k++) begin
      if (pq[k].size() > 0 && $urandom_range(99) >= vld_stall_pct) begin
        i_tvalid[k]          = 1'b1;
        i_tdata[k*64 +: 64]  = pq[k][0][63:0];
        i_tlast[k]           = pq[k][0][64];
      end else begin
        i_tvalid[k]          = 1'b0;
        i_tdata[k*64 +: 64]  = '0;
        i_tlast[k]           = 1'b0;
      end
    end
    o_tready = ($urandom_range(99) >= rdy_stall_pct);
  endtask

  // Sampled mid-cycle: compare DUT against model, then advance the model past the edge.
  task automatic monitor_cycle();
    logic [NP-1:0] exp_rdy;
    logic [64:0]   w;
    logic          exp_v;
    int            np;
    pop_mask = i_tvalid & s_rdy;
    if (s_v === 1'b1 && o_tready) begin
      obs_beats++;
      beat_cycle.push_back(cyc);
      if (s_l === 1'b1) obs_order.push_back(int'(s_g));
    end
    if (s_e === 1'b1) obs_err++;

    if (m_synced) begin
      total++; if (s_b !== m_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, s_b, m_busy); end
      total++; if (s_c !== m_pkts) begin bad++; $display("FAIL pkt_count cyc=%0d got=%0d want=%0d", cyc, s_c, m_pkts); end
      total++; if (s_e !== m_err) begin bad++; $display("FAIL len_err cyc=%0d got=%b want=%b", cyc, s_e, m_err); end
      total++; if (s_g !== m_g[1:0]) begin bad++; $display("FAIL grant_idx cyc=%0d got=%0d want=%0d", cyc, s_g, m_g); end
      exp_rdy = '0;
      if (m_busy && o_tready) exp_rdy[m_g] = 1'b1;
      total++; if (s_rdy !== exp_rdy) begin bad++; $display("FAIL i_tready cyc=%0d got=%b want=%b", cyc, s_rdy, exp_rdy); end
      exp_v = m_busy && i_tvalid[m_g];
      total++; if (s_v !== exp_v) begin bad++; $display("FAIL o_tvalid cyc=%0d got=%b want=%b", cyc, s_v, exp_v); end
      if (exp_v) begin
        w = pq[m_g][0];
        total++; if ({s_l, s_d} !== w) begin bad++; $display("FAIL data cyc=%0d got=%h want=%h", cyc, {s_l, s_d}, w); end
      end else if (!m_busy) begin
        total++; if (s_l !== 1'b0) begin bad++; $display("FAIL o_tlast_idle cyc=%0d got=%b want=0", cyc, s_l); end
      end
    end

    m_err = 1'b0;
    if (reset || clear) begin
      m_busy = 0; m_head = 0; m_g = 0; m_ptr = 0; m_pkts = '0; m_synced = 1;
    end else if (m_synced) begin
      if (!m_busy) begin
        np = model_pick(i_tvalid);
        if (np >= 0) begin m_g = np; m_busy = 1; m_head = 1; end
      end else if (i_tvalid[m_g] && o_tready) begin
        w = pq[m_g][0];
        if (m_head) begin m_len = w[47:32]; m_beats = 1; end
        else m_beats++;
        m_head = 0;
        if (w[64]) begin
          m_err  = (m_beats != (int'(m_len) + 7) / 8) || (m_len < 16'd8);
          m_pkts = m_pkts + 1;
          m_ptr  = (m_g + 1) % NP;
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) if (pop_mask[k] === 1'b1) void'(pq[k].pop_front());
    drive();
  endtask

  task automatic clear_obs();
    obs_order.delete(); beat_cycle.delete(); obs_err = 0; obs_beats = 0;
  endtask

  task automatic flush();
    for (int k = 0; k < NP; k++) pq[k].delete();
  endtask

  task automatic run_until_idle(input int max, input string name);
    int n = 0;
    while (((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) > 0 || m_busy) && n < max) begin
      step(); n++;
    end
    step(); step();
    total++;
    if (n >= max) begin bad++; $display("FAIL %s_timeout got=%0d cycles want<%0d", name, n, max); end
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; vld_stall_pct = 0; rdy_stall_pct = 0;
    flush(); drive();
    step(); step();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; i_tvalid = '0; i_tlast = '0; i_tdata = '0; o_tready = 1'b0;
    add_pkt(3, 2, 16);
    drive(); step(); step();
    #2;
    total++; if (s_rdy !== '0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_rdy); end
    total++; if (s_v !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", s_v); end
    total++; if (s_l !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", s_l); end
    total++; if (s_b !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", s_b); end
    total++; if (s_g !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", s_g); end
    total++; if (s_e !== 1'b0) begin bad++; $display("FAIL reset_len_err got=%b want=0", s_e); end
    total++; if (s_c !== 32'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d want=0", s_c); end
    do_reset();
  endtask

  task automatic test_single();
    int c_start;
    do_reset();
    add_pkt(2, 3, 24);
    drive();
    c_start = cyc;
    run_until_idle(50, "single");
    total++; if (obs_order.size() != 1 || obs_order[0] != 2) begin bad++; $display("FAIL single_grant got=%p want=2", obs_order); end
    total++; if (obs_beats != 3) begin bad++; $display("FAIL single_beats got=%0d want=3", obs_beats); end
    total++; if (beat_cycle.size() != 3 || beat_cycle[0] != c_start + 2 || beat_cycle[2] != c_start + 4) begin
      bad++; $display("FAIL single_timing got=%p want first=%0d last=%0d", beat_cycle, c_start + 2, c_start + 4);
    end
    total++; if (obs_err != 0) begin bad++; $display("FAIL single_len_err got=%0d want=0", obs_err); end
    total++; if (s_c !== 32'd1) begin bad++; $display("FAIL single_pkt_count got=%0d want=1", s_c); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 3; r++) for (int k = 0; k < NP; k++) add_pkt(k, 1, 8);
    drive();
    run_until_idle(100, "rr");
    total++; if (obs_order.size() != 12) begin bad++; $display("FAIL rr_count got=%0d want=12", obs_order.size()); end
    for (int i = 0; i < obs_order.size(); i++) begin
      total++; if (obs_order[i] != i % NP) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, obs_order[i], i % NP); end
    end
    for (int i = 1; i < beat_cycle.size(); i++) begin
      total++; if (beat_cycle[i] - beat_cycle[i-1] != 2) begin
        bad++; $display("FAIL rr_spacing[%0d] got=%0d want=2", i, beat_cycle[i] - beat_cycle[i-1]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    int want[$] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3};
    use_prio = 1;
    do_reset();
    for (int r = 0; r < 6; r++) add_pkt(0, 1, 8);
    for (int r = 0; r < 2; r++) for (int k = 1; k < NP; k++) add_pkt(k, 1, 8);
    drive();
    run_until_idle(100, "prio");
    total++; if (obs_order.size() != want.size()) begin bad++; $display("FAIL prio_count got=%0d want=%0d", obs_order.size(), want.size()); end
    for (int i = 0; i < obs_order.size() && i < want.size(); i++) begin
      total++; if (obs_order[i] != want[i]) begin bad++; $display("FAIL prio_order[%0d] got=%0d want=%0d", i, obs_order[i], want[i]); end
    end
    do_reset();
    use_prio = 0;
    do_reset();
  endtask

  task automatic test_len_err();
    do_reset();
    add_pkt(1, 4, 16);
    drive();
    run_until_idle(50, "lenerr");
    total++; if (obs_err != 1) begin bad++; $display("FAIL lenerr_pulses got=%0d want=1", obs_err); end
    total++; if (obs_beats != 4) begin bad++; $display("FAIL lenerr_beats got=%0d want=4", obs_beats); end
    clear_obs();
    add_pkt(3, 1, 8);
    add_pkt(0, 1, 4);
    add_pkt(2, 2, 9);
    drive();
    run_until_idle(50, "lenerr2");
    total++; if (obs_err != 1) begin bad++; $display("FAIL lenerr_short got=%0d want=1", obs_err); end
    total++; if (s_c !== 32'd4) begin bad++; $display("FAIL lenerr_pkt_count got=%0d want=4", s_c); end
  endtask

  task automatic test_backpressure();
    int want[$] = '{0, 3, 0, 3};
    do_reset();
    rdy_stall_pct = 40;
    for (int r = 0; r < 2; r++) begin add_pkt(0, 5, 40); add_pkt(3, 5, 40); end
    drive();
    run_until_idle(400, "bp");
    rdy_stall_pct = 0;
    total++; if (obs_beats != 20) begin bad++; $display("FAIL bp_beats got=%0d want=20", obs_beats); end
    total++; if (obs_order.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", obs_order.size()); end
    for (int i = 0; i < obs_order.size() && i < 4; i++) begin
      total++; if (obs_order[i] != want[i]) begin bad++; $display("FAIL bp_order[%0d] got=%0d want=%0d", i, obs_order[i], want[i]); end
    end
  endtask

  task automatic test_clear();
    do_reset();
    add_pkt(1, 1, 8);
    drive();
    run_until_idle(50, "clr_pre");
    add_pkt(1, 5, 40);
    drive();
    step(); step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    flush();
    drive();
    #2;
    total++; if (s_c !== 32'd0) begin bad++; $display("FAIL clear_pkt_count got=%0d want=0", s_c); end
    total++; if (s_v !== 1'b0) begin bad++; $display("FAIL clear_tvalid got=%b want=0", s_v); end
    total++; if (s_b !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", s_b); end
    clear_obs();
    add_pkt(3, 1, 8);
    add_pkt(1, 1, 8);
    drive();
    run_until_idle(50, "clr_post");
    total++; if (obs_order.size() != 2 || obs_order[0] != 1) begin bad++; $display("FAIL clear_next_grant got=%p want first=1", obs_order); end
  endtask

  task automatic test_random();
    int exp_err = 0;
    int nb, len, p;
    do_reset();
    vld_stall_pct = 20;
    rdy_stall_pct = 30;
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(NP - 1);
      nb = $urandom_range(6, 1);
      len = ($urandom_range(3) == 0) ? $urandom_range(80) : nb * 8 - $urandom_range(7);
      if (nb != (len + 7) / 8 || len < 8) exp_err++;
      add_pkt(p, nb, len);
    end
    drive();
    run_until_idle(3000, "rand");
    vld_stall_pct = 0;
    rdy_stall_pct = 0;
    total++; if (obs_order.size() != 40) begin bad++; $display("FAIL rand_pkts got=%0d want=40", obs_order.size()); end
    total++; if (obs_err != exp_err) begin bad++; $display("FAIL rand_len_err got=%0d want=%0d", obs_err, exp_err); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_len_err();
    test_backpressure();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
